// File: rtl/start_stop_button.sv
// rtl/start_stop_button.sv - debounced push-button front end producing toggle and long-press pulses
module start_stop_button #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic toggle,
    output logic long_press,
    output logic btn_level
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          s1;
    logic          s;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] deb_next;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_next;
    logic          long_done;
    logic          long_done_next;
    logic          toggle_next;
    logic          long_next;

    // two-flop synchroniser; nothing downstream looks at btn_in directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= btn_in;
            s  <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            toggle     <= 1'b0;
            long_press <= 1'b0;
        end else begin
            state      <= state_next;
            deb_cnt    <= deb_next;
            hold_cnt   <= hold_next;
            long_done  <= long_done_next;
            toggle     <= toggle_next;
            long_press <= long_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        deb_next       = deb_cnt;
        hold_next      = hold_cnt;
        long_done_next = long_done;
        toggle_next    = 1'b0;
        long_next      = 1'b0;
        case (state)
            IDLE: begin
                deb_next = s ? CNT_ONE : '0;
            end
            PRESS_WAIT: begin
                if (!s) begin
                    deb_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_next       = '0;
                    toggle_next    = 1'b1;
                    hold_next      = '0;
                    long_done_next = 1'b0;
                end else begin
                    deb_next = deb_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    deb_next = CNT_ONE;
                end else begin
                    // hold_cnt parks at its last value so a very long hold never wraps into a second pulse
                    if (hold_cnt != HOLD_LAST) begin
                        hold_next = hold_cnt + CNT_ONE;
                    end
                    if (hold_cnt == HOLD_LAST && !long_done) begin
                        long_next      = 1'b1;
                        long_done_next = 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    // a release bounce returns to PRESSED silently; the hold measurement starts over
                    deb_next  = '0;
                    hold_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_next = '0;
                end else begin
                    deb_next = deb_cnt + CNT_ONE;
                end
            end
            default: begin
                deb_next  = '0;
                hold_next = '0;
            end
        endcase
    end

    assign btn_level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_start_stop_button.sv
// tb/tb_start_stop_button.sv - directed scoreboard bench for start_stop_button
module tb_start_stop_button;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_in = 1'b0;
    logic toggle;
    logic long_press;
    logic btn_level;
    logic run;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_long;
        int at;
    } ev_t;
    ev_t exp_q[$];

    start_stop_button #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .toggle(toggle),
        .long_press(long_press),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // model of the START/STOP toggle flip-flop driven by toggle
    always @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else if (toggle) run <= ~run;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic until_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        until_cyc(n);
        @(negedge clk);
    endtask

    task automatic push(input bit is_long, input int at);
        ev_t e;
        e.is_long = is_long;
        e.at = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && (toggle || long_press)) begin
            chk("pulse exclusive", {31'd0, toggle & long_press}, 32'd0);
            chk("pulse expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                chk(e.is_long ? "long_press kind" : "toggle kind", {31'd0, long_press}, {31'd0, e.is_long});
                chk(e.is_long ? "long_press cycle" : "toggle cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int r0;
        int t0;
        int u0;
        bit exp_run;

        #1;
        chk("reset toggle", {31'd0, toggle}, 32'd0);
        chk("reset long_press", {31'd0, long_press}, 32'd0);
        chk("reset btn_level", {31'd0, btn_level}, 32'd0);
        until_cyc(3);
        rst = 1'b1;
        until_cyc(5);

        // clean press released just before the long-press point
        e0 = cyc;
        btn_in = 1'b1;
        push(0, e0 + D + 2);
        at_neg(e0 + D + 1);
        chk("clean level before", {31'd0, btn_level}, 32'd0);
        at_neg(e0 + D + 2);
        chk("clean level rise", {31'd0, btn_level}, 32'd1);
        until_cyc(e0 + 13);
        r0 = cyc;
        btn_in = 1'b0;
        at_neg(r0 + D + 1);
        chk("clean level hold", {31'd0, btn_level}, 32'd1);
        at_neg(r0 + D + 2);
        chk("clean level fall", {31'd0, btn_level}, 32'd0);
        until_cyc(cyc + 3);

        // 3-cycle glitch: ignored
        e0 = cyc;
        btn_in = 1'b1;
        until_cyc(e0 + 3);
        btn_in = 1'b0;
        until_cyc(e0 + 10);
        chk("glitch level", {31'd0, btn_level}, 32'd0);

        // minimum accepted pulse of D cycles
        e0 = cyc;
        btn_in = 1'b1;
        push(0, e0 + D + 2);
        until_cyc(e0 + D);
        btn_in = 1'b0;
        at_neg(e0 + 2 * D + 2);
        chk("min pulse level fall", {31'd0, btn_level}, 32'd0);
        until_cyc(cyc + 4);

        // bounce 1,0,1,0 then steady high, held long
        e0 = cyc;
        btn_in = 1'b1;
        until_cyc(e0 + 1); btn_in = 1'b0;
        until_cyc(e0 + 2); btn_in = 1'b1;
        until_cyc(e0 + 3); btn_in = 1'b0;
        until_cyc(e0 + 4); btn_in = 1'b1;
        push(0, e0 + 4 + D + 2);
        push(1, e0 + 4 + D + 2 + L);
        until_cyc(e0 + 4 + D + 2 + 30);
        r0 = cyc;
        btn_in = 1'b0;
        at_neg(r0 + D + 1);
        chk("long hold level hold", {31'd0, btn_level}, 32'd1);
        at_neg(r0 + D + 2);
        chk("long hold level fall", {31'd0, btn_level}, 32'd0);
        until_cyc(cyc + 3);

        // release bounce: 2-cycle dip while pressed
        e0 = cyc;
        btn_in = 1'b1;
        t0 = e0 + D + 2;
        push(0, t0);
        until_cyc(t0 + 2);
        btn_in = 1'b0;
        until_cyc(t0 + 4);
        btn_in = 1'b1;
        u0 = cyc;
        push(1, u0 + 3 + L);
        at_neg(t0 + 6);
        chk("dip level", {31'd0, btn_level}, 32'd1);
        at_neg(t0 + 7);
        chk("dip level back", {31'd0, btn_level}, 32'd1);
        until_cyc(u0 + 16);
        btn_in = 1'b0;
        until_cyc(cyc + 2 * D + 4);

        // reset during PRESS_WAIT, then during PRESSED with toggle high
        e0 = cyc;
        btn_in = 1'b1;
        until_cyc(e0 + 4);
        rst = 1'b0;
        #1;
        chk("rst pw toggle", {31'd0, toggle}, 32'd0);
        chk("rst pw long_press", {31'd0, long_press}, 32'd0);
        chk("rst pw btn_level", {31'd0, btn_level}, 32'd0);
        until_cyc(e0 + 6);
        rst = 1'b1;
        t0 = cyc + D + 2;
        until_cyc(t0);
        chk("post-rst toggle", {31'd0, toggle}, 32'd1);
        chk("post-rst level", {31'd0, btn_level}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst pr toggle", {31'd0, toggle}, 32'd0);
        chk("rst pr long_press", {31'd0, long_press}, 32'd0);
        chk("rst pr btn_level", {31'd0, btn_level}, 32'd0);
        until_cyc(t0 + 2);
        rst = 1'b1;
        e0 = cyc;
        push(0, e0 + D + 2);
        at_neg(e0 + D + 2);
        chk("held after rst level", {31'd0, btn_level}, 32'd1);
        until_cyc(e0 + 8);
        btn_in = 1'b0;
        until_cyc(cyc + 2 * D + 4);

        // integration with the start/stop flip-flop
        rst = 1'b0;
        #1;
        chk("run reset", {31'd0, run}, 32'd0);
        until_cyc(cyc + 2);
        rst = 1'b1;
        until_cyc(cyc + 2);
        exp_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e0 = cyc;
            btn_in = 1'b1;
            push(0, e0 + D + 2);
            until_cyc(e0 + D + 2);
            chk("run before toggle", {31'd0, run}, {31'd0, exp_run});
            exp_run = ~exp_run;
            until_cyc(e0 + D + 3);
            chk("run after toggle", {31'd0, run}, {31'd0, exp_run});
            until_cyc(e0 + 9);
            btn_in = 1'b0;
            until_cyc(cyc + 2 * D + 4);
        end

        until_cyc(cyc + 5);
        chk("events drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
